// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared types and default widths for the ALU reservation station.
//   alu_op_e      3-bit ALU operation encoding carried from dispatch to issue
//   RS_PREG_W     default physical register tag width
//   RS_ROB_TAG_W  default ROB tag width (must match ROB/top level)
//   RS_DATA_W     operand/result width
package alu_rs_pkg;

  localparam int unsigned RS_PREG_W    = 6;
  localparam int unsigned RS_ROB_TAG_W = 4;
  localparam int unsigned RS_DATA_W    = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_rs_age_select.sv
// alu_rs_age_select: age matrix plus oldest-requester one-hot pick.
//   clk, rst   clock, synchronous active-high reset
//   i_clr      clear all age relations (flush)
//   i_req      per-entry request (ready candidates)
//   i_alloc    one-hot entry being written this edge (younger than all)
//   i_free     one-hot entry leaving this edge
//   o_grant    one-hot oldest requester (combinational)
// r_old[i][j] = 1 means entry i is older than entry j.
module alu_rs_age_select #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  output logic [N-1:0] o_grant
);

  logic [N-1:0] r_old [N];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int unsigned i = 0; i < N; i++) r_old[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i_alloc[i] || i_free[i]) begin
          // New or departing entry is older than nobody.
          r_old[i] <= '0;
        end else begin
          // Every surviving entry becomes older than the newcomer.
          for (int unsigned j = 0; j < N; j++)
            if (i_alloc[j]) r_old[i][j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_grant[i] = i_req[i];
      for (int unsigned j = 0; j < N; j++)
        if (j != i && i_req[j] && r_old[j][i]) o_grant[i] = 1'b0;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station / issue scheduler between dispatch and the
// single-cycle ALU. Buffers uops, captures operands from the CDB, and issues
// the oldest ready entry each cycle.
//   clk, rst          clock, synchronous active-high reset
//   flush_i           squash all entries (dispatch that cycle dropped)
//   disp_*            dispatch request / operands / tags, disp_ready_o
//   cdb_*             result broadcast used for wakeup
//   iss_*             issue to ALU (zero when iss_valid_o=0)
//   free_cnt_o        number of free entries
// Optional macro ALU_RS_CDB_BYPASS_EN: select also sees the current CDB
// broadcast, so a CDB-woken uop issues in the broadcast cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_TAG_W = RS_ROB_TAG_W,
  parameter int unsigned PREG_W    = RS_PREG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  output logic                       disp_ready_o,
  input  logic [2:0]                 disp_op_i,
  input  logic [PREG_W-1:0]          disp_src1_i,
  input  logic                       disp_rdy1_i,
  input  logic [RS_DATA_W-1:0]       disp_val1_i,
  input  logic [PREG_W-1:0]          disp_src2_i,
  input  logic                       disp_rdy2_i,
  input  logic [RS_DATA_W-1:0]       disp_val2_i,
  input  logic [PREG_W-1:0]          disp_rd_p_i,
  input  logic [ROB_TAG_W-1:0]       disp_rob_i,
  input  logic                       cdb_valid_i,
  input  logic [PREG_W-1:0]          cdb_tag_i,
  input  logic [RS_DATA_W-1:0]       cdb_data_i,
  output logic                       iss_valid_o,
  output logic [2:0]                 iss_op_o,
  output logic [RS_DATA_W-1:0]       iss_op1_o,
  output logic [RS_DATA_W-1:0]       iss_op2_o,
  output logic [PREG_W-1:0]          iss_rd_p_o,
  output logic [ROB_TAG_W-1:0]       iss_rob_o,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    alu_op_e              op;
    logic [PREG_W-1:0]    src1;
    logic [PREG_W-1:0]    src2;
    logic                 rdy1;
    logic                 rdy2;
    logic [RS_DATA_W-1:0] val1;
    logic [RS_DATA_W-1:0] val2;
    logic [PREG_W-1:0]    rd_p;
    logic [ROB_TAG_W-1:0] rob;
  } rs_entry_t;

  rs_entry_t r_ent [DEPTH];

  logic [DEPTH-1:0] w_wk1, w_wk2, w_req, w_grant, w_alloc_oh;
  logic             w_disp_fire;
  rs_entry_t        w_new;
  logic [CNT_W-1:0] w_cnt;

  // Wakeup matches and select candidates.
  always_comb begin
    w_wk1 = '0;
    w_wk2 = '0;
    w_req = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_wk1[i] = r_ent[i].valid && !r_ent[i].rdy1 && cdb_valid_i && (r_ent[i].src1 == cdb_tag_i);
      w_wk2[i] = r_ent[i].valid && !r_ent[i].rdy2 && cdb_valid_i && (r_ent[i].src2 == cdb_tag_i);
`ifdef ALU_RS_CDB_BYPASS_EN
      w_req[i] = r_ent[i].valid && (r_ent[i].rdy1 || w_wk1[i]) && (r_ent[i].rdy2 || w_wk2[i]);
`else
      w_req[i] = r_ent[i].valid && r_ent[i].rdy1 && r_ent[i].rdy2;
`endif
    end
  end

  // Lowest-index free entry; its existence is disp_ready_o.
  always_comb begin
    w_alloc_oh   = '0;
    disp_ready_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!r_ent[i].valid && !disp_ready_o) begin
        w_alloc_oh[i] = 1'b1;
        disp_ready_o  = 1'b1;
      end
    end
  end

  assign w_disp_fire = disp_valid_i && disp_ready_o && !flush_i;

  // Incoming entry, including capture of a same-cycle CDB broadcast.
  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.op    = alu_op_e'(disp_op_i);
    w_new.src1  = disp_src1_i;
    w_new.src2  = disp_src2_i;
    w_new.rd_p  = disp_rd_p_i;
    w_new.rob   = disp_rob_i;
    w_new.rdy1  = disp_rdy1_i || (cdb_valid_i && cdb_tag_i == disp_src1_i);
    w_new.rdy2  = disp_rdy2_i || (cdb_valid_i && cdb_tag_i == disp_src2_i);
    w_new.val1  = disp_rdy1_i ? disp_val1_i : cdb_data_i;
    w_new.val2  = disp_rdy2_i ? disp_val2_i : cdb_data_i;
  end

  alu_rs_age_select #(.N(DEPTH)) u_age (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush_i),
    .i_req   (w_req),
    .i_alloc (w_alloc_oh & {DEPTH{w_disp_fire}}),
    .i_free  (w_grant),
    .o_grant (w_grant)
  );

  // Issue mux; grant is one-hot so outputs stay zero when nothing issues.
  always_comb begin
    iss_valid_o = |w_grant;
    iss_op_o    = '0;
    iss_op1_o   = '0;
    iss_op2_o   = '0;
    iss_rd_p_o  = '0;
    iss_rob_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        iss_op_o   = r_ent[i].op;
        iss_rd_p_o = r_ent[i].rd_p;
        iss_rob_o  = r_ent[i].rob;
`ifdef ALU_RS_CDB_BYPASS_EN
        iss_op1_o  = w_wk1[i] ? cdb_data_i : r_ent[i].val1;
        iss_op2_o  = w_wk2[i] ? cdb_data_i : r_ent[i].val2;
`else
        iss_op1_o  = r_ent[i].val1;
        iss_op2_o  = r_ent[i].val2;
`endif
      end
    end
  end

  always_comb begin
    w_cnt = CNT_W'(DEPTH);
    for (int unsigned i = 0; i < DEPTH; i++)
      if (r_ent[i].valid) w_cnt = w_cnt - CNT_W'(1);
  end
  assign free_cnt_o = w_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_grant[i]) begin
          r_ent[i].valid <= 1'b0;
        end else if (w_alloc_oh[i] && w_disp_fire) begin
          r_ent[i] <= w_new;
        end else begin
          if (w_wk1[i]) begin
            r_ent[i].rdy1 <= 1'b1;
            r_ent[i].val1 <= cdb_data_i;
          end
          if (w_wk2[i]) begin
            r_ent[i].rdy2 <= 1'b1;
            r_ent[i].val2 <= cdb_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed, table-driven bench for alu_rs plus hand-written
// sequences for age ordering, flush and mid-operation reset.
module tb_alu_rs;
  import alu_rs_pkg::*;

`ifdef ALU_RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        disp_valid_i = 1'b0;
  logic        disp_ready_o;
  logic [2:0]  disp_op_i = '0;
  logic [5:0]  disp_src1_i = '0;
  logic        disp_rdy1_i = 1'b0;
  logic [31:0] disp_val1_i = '0;
  logic [5:0]  disp_src2_i = '0;
  logic        disp_rdy2_i = 1'b0;
  logic [31:0] disp_val2_i = '0;
  logic [5:0]  disp_rd_p_i = '0;
  logic [3:0]  disp_rob_i = '0;
  logic        cdb_valid_i = 1'b0;
  logic [5:0]  cdb_tag_i = '0;
  logic [31:0] cdb_data_i = '0;
  logic        iss_valid_o;
  logic [2:0]  iss_op_o;
  logic [31:0] iss_op1_o, iss_op2_o;
  logic [5:0]  iss_rd_p_o;
  logic [3:0]  iss_rob_o;
  logic [2:0]  free_cnt_o;

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(4), .ROB_TAG_W(4), .PREG_W(6)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_op_i(disp_op_i),
    .disp_src1_i(disp_src1_i), .disp_rdy1_i(disp_rdy1_i), .disp_val1_i(disp_val1_i),
    .disp_src2_i(disp_src2_i), .disp_rdy2_i(disp_rdy2_i), .disp_val2_i(disp_val2_i),
    .disp_rd_p_i(disp_rd_p_i), .disp_rob_i(disp_rob_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .iss_valid_o(iss_valid_o), .iss_op_o(iss_op_o), .iss_op1_o(iss_op1_o),
    .iss_op2_o(iss_op2_o), .iss_rd_p_o(iss_rd_p_o), .iss_rob_o(iss_rob_o),
    .free_cnt_o(free_cnt_o)
  );

  typedef struct {
    logic        dv;
    logic [2:0]  op;
    logic [5:0]  s1;
    logic        r1;
    logic [31:0] v1;
    logic [5:0]  s2;
    logic        r2;
    logic [31:0] v2;
    logic [5:0]  rd;
    logic [3:0]  rob;
    logic        cv;
    logic [5:0]  ct;
    logic [31:0] cd;
    logic        fl;
    logic        e_iv;
    logic [2:0]  e_op;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [5:0]  e_rd;
    logic [2:0]  e_fc;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t dsp(input logic [2:0] op, input logic [5:0] s1, input logic r1,
                               input logic [31:0] v1, input logic [5:0] s2, input logic r2,
                               input logic [31:0] v2, input logic [5:0] rd, input logic [3:0] rob);
    vec_t v;
    v = idle();
    v.dv = 1'b1; v.op = op; v.s1 = s1; v.r1 = r1; v.v1 = v1;
    v.s2 = s2; v.r2 = r2; v.v2 = v2; v.rd = rd; v.rob = rob;
    return v;
  endfunction

  function automatic vec_t cdb(input vec_t vi, input logic [5:0] t, input logic [31:0] d);
    vec_t v;
    v = vi;
    v.cv = 1'b1; v.ct = t; v.cd = d;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic iv, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] rd, input logic [2:0] fc);
    vec_t v;
    v = vi;
    v.e_iv = iv; v.e_op = op; v.e_op1 = a; v.e_op2 = b; v.e_rd = rd; v.e_fc = fc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    disp_valid_i = v.dv; disp_op_i = v.op;
    disp_src1_i = v.s1; disp_rdy1_i = v.r1; disp_val1_i = v.v1;
    disp_src2_i = v.s2; disp_rdy2_i = v.r2; disp_val2_i = v.v2;
    disp_rd_p_i = v.rd; disp_rob_i = v.rob;
    cdb_valid_i = v.cv; cdb_tag_i = v.ct; cdb_data_i = v.cd;
    flush_i = v.fl;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = ex(idle(), 0, 0, 0, 0, 0, 4);
    tbl[1]  = ex(dsp(ALU_ADD, 1, 1, 5, 2, 1, 7, 10, 1), 0, 0, 0, 0, 0, 4);
    tbl[2]  = ex(idle(), 1, ALU_ADD, 5, 7, 10, 3);
    tbl[3]  = ex(idle(), 0, 0, 0, 0, 0, 4);
    tbl[4]  = ex(dsp(ALU_SUB, 9, 0, 0, 3, 1, 3, 11, 2), 0, 0, 0, 0, 0, 4);
    tbl[5]  = ex(idle(), 0, 0, 0, 0, 0, 3);
    tbl[6]  = ex(cdb(idle(), 9, 100), BYP, BYP ? 3'(ALU_SUB) : 3'd0,
                 BYP ? 32'd100 : 32'd0, BYP ? 32'd3 : 32'd0, BYP ? 6'd11 : 6'd0, 3);
    tbl[7]  = ex(idle(), !BYP, !BYP ? 3'(ALU_SUB) : 3'd0,
                 !BYP ? 32'd100 : 32'd0, !BYP ? 32'd3 : 32'd0, !BYP ? 6'd11 : 6'd0,
                 BYP ? 3'd4 : 3'd3);
    tbl[8]  = ex(idle(), 0, 0, 0, 0, 0, 4);
    tbl[9]  = ex(cdb(dsp(ALU_OR, 1, 1, 32'h11, 20, 0, 0, 12, 3), 20, 32'h55), 0, 0, 0, 0, 0, 4);
    tbl[10] = ex(idle(), 1, ALU_OR, 32'h11, 32'h55, 12, 3);
    tbl[11] = ex(idle(), 0, 0, 0, 0, 0, 4);

    apply(idle());
    tick(); tick();
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      apply(tbl[k]);
      chk($sformatf("v%0d.iss_valid", k), 32'(iss_valid_o), 32'(tbl[k].e_iv));
      chk($sformatf("v%0d.iss_op", k),    32'(iss_op_o),    32'(tbl[k].e_op));
      chk($sformatf("v%0d.iss_op1", k),   iss_op1_o,        tbl[k].e_op1);
      chk($sformatf("v%0d.iss_op2", k),   iss_op2_o,        tbl[k].e_op2);
      chk($sformatf("v%0d.iss_rd", k),    32'(iss_rd_p_o),  32'(tbl[k].e_rd));
      chk($sformatf("v%0d.free_cnt", k),  32'(free_cnt_o),  32'(tbl[k].e_fc));
      chk($sformatf("v%0d.disp_ready", k), 32'(disp_ready_o), 32'(tbl[k].e_fc != 0));
      tick();
    end

    // Age ordering: third-dispatched uop lands in a lower index than the first.
    apply(dsp(ALU_ADD, 40, 0, 0, 0, 1, 1, 20, 4)); tick();            // X  -> e0
    apply(dsp(ALU_ADD, 30, 0, 0, 0, 1, 2, 21, 5)); tick();            // U1 -> e1
    apply(cdb(dsp(ALU_ADD, 31, 0, 0, 0, 1, 3, 22, 6), 40, 0)); tick(); // U2 -> e2, X woken
    apply(idle()); tick();                                            // X gone by now
    apply(dsp(ALU_ADD, 30, 0, 0, 0, 1, 4, 23, 7)); tick();            // U3 -> e0
    apply(dsp(ALU_ADD, 32, 0, 0, 0, 1, 5, 24, 8)); tick();            // U4 -> e3
    apply(cdb(idle(), 30, 32'hAA));
    chk("full.disp_ready", 32'(disp_ready_o), 0);
    chk("full.free_cnt", 32'(free_cnt_o), 0);
    chk("age0.iss_valid", 32'(iss_valid_o), 32'(BYP));
    chk("age0.iss_rd", 32'(iss_rd_p_o), BYP ? 32'd21 : 32'd0);
    chk("age0.iss_op1", iss_op1_o, BYP ? 32'hAA : 32'd0);
    tick();
    apply(idle());
    chk("age1.iss_valid", 32'(iss_valid_o), 1);
    chk("age1.iss_rd", 32'(iss_rd_p_o), BYP ? 32'd23 : 32'd21);
    chk("age1.iss_op1", iss_op1_o, 32'hAA);
    chk("age1.iss_op2", iss_op2_o, BYP ? 32'd4 : 32'd2);
    chk("age1.free_cnt", 32'(free_cnt_o), BYP ? 32'd1 : 32'd0);
    tick();
    chk("age2.iss_valid", 32'(iss_valid_o), 32'(!BYP));
    chk("age2.iss_rd", 32'(iss_rd_p_o), BYP ? 32'd0 : 32'd23);
    chk("age2.free_cnt", 32'(free_cnt_o), BYP ? 32'd2 : 32'd1);
    tick();
    chk("age3.iss_valid", 32'(iss_valid_o), 0);
    chk("age3.free_cnt", 32'(free_cnt_o), 2);
    chk("age3.disp_ready", 32'(disp_ready_o), 1);

    // Flush with three valid entries and a concurrent dispatch.
    apply(dsp(ALU_XOR, 0, 1, 32'h77, 0, 1, 1, 25, 9)); tick();
    v = dsp(ALU_AND, 0, 1, 32'h99, 0, 1, 2, 26, 10);
    v.fl = 1'b1;
    apply(v);
    chk("flush.iss_valid", 32'(iss_valid_o), 1);
    chk("flush.iss_op1", iss_op1_o, 32'h77);
    chk("flush.iss_rd", 32'(iss_rd_p_o), 25);
    chk("flush.free_cnt", 32'(free_cnt_o), 1);
    tick();
    apply(idle());
    chk("postflush.free_cnt", 32'(free_cnt_o), 4);
    chk("postflush.iss_valid", 32'(iss_valid_o), 0);
    chk("postflush.disp_ready", 32'(disp_ready_o), 1);
    tick();
    chk("postflush2.iss_valid", 32'(iss_valid_o), 0);
    tick();

    // Mid-operation reset with two pending entries and a dispatch in the reset cycle.
    apply(dsp(ALU_ADD, 50, 0, 0, 0, 1, 1, 27, 11)); tick();
    apply(dsp(ALU_ADD, 51, 0, 0, 0, 1, 1, 28, 12)); tick();
    chk("prerst.free_cnt", 32'(free_cnt_o), 2);
    rst = 1'b1;
    apply(dsp(ALU_ADD, 0, 1, 1, 0, 1, 1, 29, 13)); tick();
    rst = 1'b0;
    apply(idle());
    chk("rst.iss_valid", 32'(iss_valid_o), 0);
    chk("rst.free_cnt", 32'(free_cnt_o), 4);
    apply(cdb(idle(), 50, 1));
    chk("rst.wake50.iss_valid", 32'(iss_valid_o), 0);
    tick();
    apply(cdb(idle(), 51, 2));
    chk("rst.wake51.iss_valid", 32'(iss_valid_o), 0);
    tick();
    apply(idle());
    chk("rst.end.iss_valid", 32'(iss_valid_o), 0);
    chk("rst.end.free_cnt", 32'(free_cnt_o), 4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
